// File: rtl/gr_wb_arbiter_pkg.sv
// Shared datapath constants for the writeback arbiter slice: register-index
// width, data width, writeback FIFO depth and the FIFO entry layout.
package gr_wb_arbiter_pkg;

  localparam int REG_W      = 5;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;

  // One buffered writeback: destination register index plus write data.
  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // True when a read index names a real register (not r0) equal to a write target.
  function automatic logic reg_hit(input logic [REG_W-1:0] rd_idx,
                                   input logic [REG_W-1:0] wr_idx);
    return (rd_idx != '0) && (rd_idx == wr_idx);
  endfunction

endpackage

// File: rtl/gr_wb_fifo2.sv
// Two-entry in-order FIFO for long-latency writebacks. Pointers are single
// bits that wrap; occupancy comes from the registered count. Also reports
// whether either decode read index hits a currently buffered entry.
module gr_wb_fifo2
  import gr_wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  input  logic [REG_W-1:0] rreg1,
  input  logic [REG_W-1:0] rreg2,
  output logic             full,
  output logic             empty,
  output wb_entry_t        head,
  output logic             match1,
  output logic             match2
);

  logic [1:0]            count;
  logic                  wptr;
  logic                  rptr;
  wb_entry_t             mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] occupied;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (do_push) wptr <= ~wptr;
      if (do_pop)  rptr <= ~rptr;
      if (do_push && !do_pop) begin
        count <= count + 2'd1;
      end else if (do_pop && !do_push) begin
        count <= count - 2'd1;
      end
    end
  end

  // Entry storage needs no reset; stale slots are masked by the occupancy map.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_entry;
  end

  // Which slots hold live entries: the head slot once non-empty, both when full.
  always_comb begin
    occupied = '0;
    if (count != 2'd0) occupied[rptr]  = 1'b1;
    if (count == 2'd2) occupied[~rptr] = 1'b1;
  end

  // Hazard lookup of both decode read indices against live entries.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (occupied[i] && reg_hit(rreg1, mem[i].wreg)) match1 = 1'b1;
      if (occupied[i] && reg_hit(rreg2, mem[i].wreg)) match2 = 1'b1;
    end
  end

endmodule

// File: rtl/gr_wb_arbiter.sv
// Register-file writeback arbiter. The pipeline (A) has priority and no
// backpressure; long-latency results (B) are buffered in a 2-entry FIFO and
// drained when the pipeline is not writing. One write per cycle, registered
// onto the write port with one cycle of latency.
// Optional macro GR_WB_ARBITER_STARVE_EN adds a starvation counter that
// stalls the pipeline for one cycle when the FIFO head has waited
// STARVE_LIMIT cycles; without it stall_a is constant 0.
module gr_wb_arbiter
  import gr_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  input  logic [REG_W-1:0]  b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [REG_W-1:0]  wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic              stall_a,
  input  logic [REG_W-1:0]  rreg1,
  input  logic [REG_W-1:0]  rreg2,
  output logic              pend1,
  output logic              pend2
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("gr_wb_arbiter: STARVE_LIMIT must lie in 1..15");
  end

  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;
  logic      a_sel;
  logic      match1;
  logic      match2;
  wb_entry_t fifo_head;
  wb_entry_t b_entry;

  // b_ready looks only at the registered fullness, never at a same-cycle pop.
  assign b_ready   = !fifo_full && !rst;
  assign b_entry   = '{wreg: b_reg, data: b_data};
  // Writes to r0 are accepted on the handshake but never buffered.
  assign fifo_push = b_valid && b_ready && (b_reg != '0);
  // A pipeline request seen while stalled is a protocol violation and is ignored.
  assign a_sel     = a_valid && (a_reg != '0) && !stall_a;
  assign fifo_pop  = !fifo_empty && !a_sel;

  gr_wb_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (b_entry),
    .pop        (fifo_pop),
    .rreg1      (rreg1),
    .rreg2      (rreg2),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head),
    .match1     (match1),
    .match2     (match2)
  );

  // Register the selected write; idle cycles park the port at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else if (a_sel) begin
      wr_en   <= 1'b1;
      wr_reg  <= a_reg;
      wr_data <= a_data;
    end else if (fifo_pop) begin
      wr_en   <= 1'b1;
      wr_reg  <= fifo_head.wreg;
      wr_data <= fifo_head.data;
    end else begin
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end
  end

  // A read index is pending while its write sits in the FIFO or on the write port.
  assign pend1 = match1 || (wr_en && reg_hit(rreg1, wr_reg));
  assign pend2 = match2 || (wr_en && reg_hit(rreg2, wr_reg));

`ifdef GR_WB_ARBITER_STARVE_EN
  logic [3:0] starve_cnt;

  // Count cycles the head waits; on reaching the limit stall the pipeline once.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
      stall_a    <= 1'b0;
    end else if (fifo_empty || fifo_pop) begin
      starve_cnt <= 4'd0;
      stall_a    <= 1'b0;
    end else if ((starve_cnt + 4'd1) >= 4'(STARVE_LIMIT)) begin
      starve_cnt <= 4'd0;
      stall_a    <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + 4'd1;
      stall_a    <= 1'b0;
    end
  end
`else
  assign stall_a = 1'b0;
`endif

endmodule

// File: doc/gr_wb_arbiter.md
GR_WB_ARBITER -- requirements
Module: gr_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: cycles the FIFO head may wait before the arbiter forces a pipeline stall (range 1..15).
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports a_valid/a_reg/a_data, input, 1/5/32: pipeline writeback request; high priority, no backpressure.
REQ-005 SHALL have ports b_valid/b_reg/b_data, input, 1/5/32: long-latency unit (mul/div) writeback request.
REQ-006 SHALL have port b_ready, output, 1: B request accepted on a cycle where b_valid && b_ready.
REQ-007 SHALL have ports wr_en/wr_reg/wr_data, output, 1/5/32: drives the register-file write port (regwrite/Wreg1/Wdata).
REQ-008 SHALL have port stall_a, output, 1: the pipeline shall not assert a_valid in the next cycle.
REQ-009 SHALL have ports rreg1/rreg2, input, 5: register-file read indices under decode.
REQ-010 SHALL have ports pend1/pend2, output, 1: the read index has an undelivered write pending.

Function
REQ-011 SHALL buffer accepted B requests in a 2-entry in-order FIFO (count 0..2, 1-bit wrapping read/write pointers).
REQ-012 SHALL drive b_ready = (count < 2) && !rst, computed from the registered count only, so a full FIFO popping in the same cycle still reports b_ready=0.
REQ-013 SHALL accept and then discard a B request with b_reg==0: no push and no write.
REQ-014 SHALL select one write per cycle. Priority: a_valid with a_reg!=0 and stall_a==0 first; otherwise the FIFO head, which pops.
REQ-015 SHALL register the selected write into wr_en/wr_reg/wr_data, giving exactly 1 cycle of latency from request to write port.
REQ-016 SHALL drive wr_en=0 in any cycle with nothing selected, and SHALL never drive wr_en=1 with wr_reg==0.
REQ-017 SHALL perform push and pop in the same cycle with count unchanged and pointers both advancing; with count==0 a same-cycle push is not bypassed and is written no earlier than the next cycle.
REQ-018 SHALL ignore a_valid in any cycle where stall_a==1 (protocol violation) and pop the FIFO head in that cycle.
REQ-019 SHALL assert pend1 iff rreg1!=0 and rreg1 matches a valid FIFO entry or (wr_en && wr_reg); pend2 likewise for rreg2. Combinational.
REQ-020 SHALL write pipeline and FIFO writes to the same register in acceptance order, with no reordering among B entries.

Reset
REQ-021 SHALL, while rst=1 at a rising edge, clear count, pointers, starvation counter, wr_en, wr_reg, wr_data and stall_a to 0.
REQ-022 SHALL drop in-flight FIFO entries on reset mid-operation, with no write issued afterward; pend1/pend2 SHALL read 0 the cycle after reset.

Configuration
REQ-023 With macro GR_WB_ARBITER_STARVE_EN defined:
  - a 4-bit counter increments each cycle the FIFO is non-empty and the head is not popped;
  - it clears on pop or when the FIFO is empty;
  - on reaching STARVE_LIMIT, stall_a=1 for exactly one following cycle and the counter clears.
REQ-024 Without GR_WB_ARBITER_STARVE_EN, stall_a SHALL be tied 0 and no counter SHALL be synthesized; B drains only in cycles without a pipeline write.

Structure
REQ-025 SHALL take register-index width (5), data width (32) and the FIFO depth constant (2) from the shared datapath package, alongside the FIFO-entry typedef {reg[4:0], data[31:0]}.
REQ-026 SHALL implement the FIFO as one sub-module, gr_wb_fifo2 (push/pop/full/empty/head, entry-match outputs for pend); arbitration and starvation logic remain in the top module.

Verification
REQ-027 Idle reset: rst high 2 cycles, then low -> wr_en=0, stall_a=0, b_ready=1, pend1=pend2=0.
REQ-028 Priority: a_valid (reg 3, 0x11) and b_valid (reg 4, 0x22) in the same cycle:
  - next cycle: wr_en, reg 3, 0x11;
  - following cycle with a_valid=0: reg 4, 0x22.
REQ-029 Full FIFO: a_valid held high (reg 5), three B pushes offered:
  - b_ready drops after two accepts;
  - pend1=1 for rreg1=B's first reg;
  - the third request is held until a pop.
REQ-030 Starvation (macro on, STARVE_LIMIT=4): a_valid continuous, one B entry -> stall_a=1 on the 5th cycle and the B write appears one cycle later.
REQ-031 Zero register: a_valid reg 0 and b_valid reg 0 -> wr_en stays 0, count stays 0, b_ready stays 1.
REQ-032 Mid-operation reset: two entries buffered, rst pulsed for 1 cycle -> no wr_en afterward, count=0.
